seq_mult7: RTL

Sequential 7x7 unsigned shift-and-add multiplier producing a 14-bit product. It is the control and accumulator stage that drives one instance of the existing 7-bit ripple adder `level` (a[6:0], b[6:0] → product[6:0], c_out). It consumes that adder's sum and carry once per cycle, and iterates seven times instead of building a full adder array. It sits between the operand source and the result consumer and uses a start/done handshake.

---
 rtl/seq_mult7.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_mult7.sv
// seq_mult7: sequential 7x7 unsigned shift-and-add multiplier.
// One 7-bit ripple adder (level) is reused once per cycle for seven steps.
// The 14-bit product appears with a one-cycle done pulse 7 cycles after the
// accepting edge.

// level: 7-bit combinational ripple-carry adder, sum plus carry out.
module level (
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] product,
  output logic       c_out
);

  logic [7:0] carry;

  // Ripple the carry bit by bit from the LSB upward.
  always_comb begin
    carry   = '0;
    product = '0;
    for (int i = 0; i < 7; i++) begin
      product[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[7];
  end

endmodule

module seq_mult7 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  a,
  input  logic [6:0]  b,
  output logic        busy,
  output logic        done,
  output logic [13:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [6:0]  m_q;
  logic [6:0]  hi_q;
  logic [6:0]  q_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [13:0] product_q;

  logic [6:0]  addend;
  logic [6:0]  sum;
  logic        c_out;
  logic [6:0]  hi_d;
  logic [6:0]  q_d;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend = q_q[0] ? m_q : 7'd0;

  level u_level (
    .a       (hi_q),
    .b       (addend),
    .product (sum),
    .c_out   (c_out)
  );

  // Shift {carry, sum, Q} right by one. The adder carry lands in HI[6],
  // so it needs no flop of its own.
  assign hi_d = {c_out, sum[6:1]};
  assign q_d  = {sum[0], q_q[6:1]};

  // Control FSM plus accumulator datapath; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 3'd0;
      product_q <= 14'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            hi_q    <= 7'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= {hi_d, q_d};
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
